// File: rtl/usb4_logical_layer_no_scr_pkg.sv
// Shared types and constants for the USB4 logical layer (no scrambler):
// state encoding, ordered-set symbols, config addresses and ID value.
package usb4_ll_pkg;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_WAIT_SB  = 3'd1,
        ST_TS1      = 3'd2,
        ST_TS2      = 3'd3,
        ST_CL0      = 3'd4
    } ll_state_t;

    localparam logic [7:0]  OS_COM      = 8'hBC;
    localparam logic [7:0]  OS_TS1      = 8'h01;
    localparam logic [7:0]  OS_TS2      = 8'h02;
    localparam logic [7:0]  SYM_IDLE    = 8'h00;

    localparam logic [7:0]  ADDR_ID     = 8'h00;
    localparam logic [7:0]  ADDR_STATUS = 8'h01;
    localparam logic [7:0]  ADDR_CTRL   = 8'h02;
    localparam logic [7:0]  ADDR_ERR    = 8'h03;

    localparam logic [31:0] LL_ID       = 32'h5553_4234;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/usb4_logical_layer_no_scr_if.sv
// Bundle of the config, transport-side and electrical-side signals of the
// logical layer; slave = the layer itself, master = whoever drives it.
interface usb4_logical_layer_no_scr_if;
    logic        lane_disable;
    logic        c_read;
    logic        c_write;
    logic [7:0]  c_address;
    logic [31:0] c_data_in;
    logic [31:0] c_data_out;
    logic [15:0] transport_layer_data_in;
    logic [15:0] transport_layer_data_out;
    logic [7:0]  lane_0_rx_i;
    logic [7:0]  lane_1_rx_i;
    logic        enable_deser;
    logic        sbrx;
    logic        sbtx;
    logic [7:0]  lane_0_tx_o;
    logic [7:0]  lane_1_tx_o;
    logic        enable_scr;

    modport slave (
        input  lane_disable, c_read, c_write, c_address, c_data_in,
               transport_layer_data_in, lane_0_rx_i, lane_1_rx_i,
               enable_deser, sbrx,
        output c_data_out, transport_layer_data_out, sbtx,
               lane_0_tx_o, lane_1_tx_o, enable_scr
    );

    modport master (
        output lane_disable, c_read, c_write, c_address, c_data_in,
               transport_layer_data_in, lane_0_rx_i, lane_1_rx_i,
               enable_deser, sbrx,
        input  c_data_out, transport_layer_data_out, sbtx,
               lane_0_tx_o, lane_1_tx_o, enable_scr
    );
endinterface

// File: rtl/usb4_ll_os_detect.sv
// Per-lane ordered-set detector: aligns on 0xBC, checks type/lane id/pad and
// keeps consecutive TS1-or-TS2 and TS2 counts. LL_OS_ERR_CNT_EN adds o_os_err.
module usb4_ll_os_detect
    import usb4_ll_pkg::*;
#(
    parameter logic [7:0] LANE_ID = 8'h00
) (
    input  logic       local_clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_sym,
    output logic [7:0] o_cnt_any,
    output logic [7:0] o_cnt_ts2
`ifdef LL_OS_ERR_CNT_EN
    ,
    output logic       o_os_err
`endif
);

    // r_pos == 0 means hunting for 0xBC, otherwise index of the expected byte
    logic [1:0] r_pos;
    logic       r_is_ts2;
    logic [7:0] r_cnt_any;
    logic [7:0] r_cnt_ts2;
    logic       w_bad;

    always_comb begin
        w_bad = 1'b0;
        case (r_pos)
            2'd1:    w_bad = (i_sym != OS_TS1) && (i_sym != OS_TS2);
            2'd2:    w_bad = (i_sym != LANE_ID);
            2'd3:    w_bad = (i_sym != SYM_IDLE);
            default: w_bad = 1'b0;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_pos     <= 2'd0;
            r_is_ts2  <= 1'b0;
            r_cnt_any <= 8'd0;
            r_cnt_ts2 <= 8'd0;
        end else if (i_clr) begin
            r_pos     <= 2'd0;
            r_cnt_any <= 8'd0;
            r_cnt_ts2 <= 8'd0;
        end else if (i_en) begin
            if (r_pos == 2'd0) begin
                if (i_sym == OS_COM) r_pos <= 2'd1;
            end else if (w_bad) begin
                r_pos     <= 2'd0;
                r_cnt_any <= 8'd0;
                r_cnt_ts2 <= 8'd0;
            end else if (r_pos == 2'd3) begin
                r_pos     <= 2'd0;
                r_cnt_any <= sat_inc8(r_cnt_any);
                r_cnt_ts2 <= r_is_ts2 ? sat_inc8(r_cnt_ts2) : 8'd0;
            end else begin
                if (r_pos == 2'd1) r_is_ts2 <= (i_sym == OS_TS2);
                r_pos <= r_pos + 2'd1;
            end
        end
    end

`ifdef LL_OS_ERR_CNT_EN
    logic r_os_err;

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) r_os_err <= 1'b0;
        else      r_os_err <= !i_clr && i_en && (r_pos != 2'd0) && w_bad;
    end

    assign o_os_err = r_os_err;
`endif

    assign o_cnt_any = r_cnt_any;
    assign o_cnt_ts2 = r_cnt_ts2;

endmodule

// File: rtl/usb4_logical_layer_no_scr.sv
// USB4 logical layer without scrambler: sideband connect detect, two-lane
// TS1/TS2 training, CL0 striping, config space. LL_OS_ERR_CNT_EN adds reg 0x03.
module usb4_logical_layer_no_scr
    import usb4_ll_pkg::*;
#(
    parameter int SB_DEBOUNCE = 16,
    parameter int TS_RX_CNT   = 8,
    parameter int TS_TX_MIN   = 16
) (
    input  logic                          local_clk,
    input  logic                          rst,
    usb4_logical_layer_no_scr_if.slave    bus
);

    localparam logic [7:0] SB_DB_L   = 8'(SB_DEBOUNCE);
    localparam logic [7:0] RX_CNT_L  = 8'(TS_RX_CNT);
    localparam logic [7:0] TX_MIN_M1 = 8'(TS_TX_MIN - 1);

    ll_state_t   r_state, w_next;
    logic        r_sb_meta, r_sb_sync;
    logic [7:0]  r_sb_hi, r_sb_lo;
    logic [1:0]  r_tx_pos;
    logic [7:0]  r_ts2_sent;
    logic [1:0]  r_ctrl;
    logic [31:0] r_c_data_out;
    logic [15:0] r_data_out;
    logic [31:0] w_rd_mux;
    logic [7:0]  w_tx0, w_tx1, w_os_type;
    logic [7:0]  w_cnt_any0, w_cnt_ts20, w_cnt_any1, w_cnt_ts21;
    logic        w_lane1_act, w_link_off, w_sb_up, w_sb_down, w_os_end;
    logic        w_det_clr, w_rx_any_ok, w_rx_ts2_ok;

    assign w_lane1_act = !r_ctrl[1];
    assign w_link_off  = bus.lane_disable || !r_ctrl[0];
    assign w_sb_up     = (r_sb_hi == SB_DB_L);
    assign w_sb_down   = (r_sb_lo == SB_DB_L);
    assign w_os_end    = (r_tx_pos == 2'd3);
    assign w_det_clr   = (r_state == ST_DISABLED) || (r_state == ST_WAIT_SB);
    assign w_rx_any_ok = (w_cnt_any0 >= RX_CNT_L) && (!w_lane1_act || w_cnt_any1 >= RX_CNT_L);
    assign w_rx_ts2_ok = (w_cnt_ts20 >= RX_CNT_L) && (!w_lane1_act || w_cnt_ts21 >= RX_CNT_L);

`ifdef LL_OS_ERR_CNT_EN
    logic        w_err0, w_err1;
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;
`endif

    usb4_ll_os_detect #(.LANE_ID(8'h00)) u_det0 (
        .local_clk (local_clk),
        .rst       (rst),
        .i_clr     (w_det_clr),
        .i_en      (bus.enable_deser),
        .i_sym     (bus.lane_0_rx_i),
        .o_cnt_any (w_cnt_any0),
        .o_cnt_ts2 (w_cnt_ts20)
`ifdef LL_OS_ERR_CNT_EN
        ,
        .o_os_err  (w_err0)
`endif
    );

    usb4_ll_os_detect #(.LANE_ID(8'h01)) u_det1 (
        .local_clk (local_clk),
        .rst       (rst),
        .i_clr     (w_det_clr || !w_lane1_act),
        .i_en      (bus.enable_deser),
        .i_sym     (bus.lane_1_rx_i),
        .o_cnt_any (w_cnt_any1),
        .o_cnt_ts2 (w_cnt_ts21)
`ifdef LL_OS_ERR_CNT_EN
        ,
        .o_os_err  (w_err1)
`endif
    );

    // Sideband: 2-flop sync, then run-length counters for each level
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_sb_meta <= 1'b0;
            r_sb_sync <= 1'b0;
            r_sb_hi   <= 8'd0;
            r_sb_lo   <= 8'd0;
        end else begin
            r_sb_meta <= bus.sbrx;
            r_sb_sync <= r_sb_meta;
            if (r_sb_sync) begin
                r_sb_lo <= 8'd0;
                if (r_sb_hi != SB_DB_L) r_sb_hi <= r_sb_hi + 8'd1;
            end else begin
                r_sb_hi <= 8'd0;
                if (r_sb_lo != SB_DB_L) r_sb_lo <= r_sb_lo + 8'd1;
            end
        end
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) r_state <= ST_DISABLED;
        else      r_state <= w_next;
    end

    // Training transitions wait for an OS boundary so the partner never sees a truncated OS
    always_comb begin
        w_next = r_state;
        if (w_link_off) begin
            w_next = ST_DISABLED;
        end else if (r_state != ST_DISABLED && w_sb_down) begin
            w_next = ST_WAIT_SB;
        end else begin
            case (r_state)
                ST_DISABLED: w_next = ST_WAIT_SB;
                ST_WAIT_SB:  if (w_sb_up) w_next = ST_TS1;
                ST_TS1:      if (w_os_end && w_rx_any_ok) w_next = ST_TS2;
                ST_TS2:      if (w_os_end && w_rx_ts2_ok && r_ts2_sent >= TX_MIN_M1)
                                 w_next = ST_CL0;
                ST_CL0:      w_next = ST_CL0;
                default:     w_next = ST_DISABLED;
            endcase
        end
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_tx_pos   <= 2'd0;
            r_ts2_sent <= 8'd0;
        end else begin
            if (r_state == ST_TS1 || r_state == ST_TS2) r_tx_pos <= r_tx_pos + 2'd1;
            else                                        r_tx_pos <= 2'd0;
            if (r_state != ST_TS2)  r_ts2_sent <= 8'd0;
            else if (w_os_end)      r_ts2_sent <= sat_inc8(r_ts2_sent);
        end
    end

    always_comb begin
        w_tx0     = SYM_IDLE;
        w_tx1     = SYM_IDLE;
        w_os_type = (r_state == ST_TS2) ? OS_TS2 : OS_TS1;
        case (r_state)
            ST_TS1, ST_TS2: begin
                case (r_tx_pos)
                    2'd0: begin w_tx0 = OS_COM;    w_tx1 = OS_COM;    end
                    2'd1: begin w_tx0 = w_os_type; w_tx1 = w_os_type; end
                    2'd2: begin w_tx0 = 8'h00;     w_tx1 = 8'h01;     end
                    default: begin w_tx0 = SYM_IDLE; w_tx1 = SYM_IDLE; end
                endcase
            end
            ST_CL0: begin
                w_tx0 = bus.transport_layer_data_in[7:0];
                w_tx1 = bus.transport_layer_data_in[15:8];
            end
            default: ;
        endcase
        if (!w_lane1_act) w_tx1 = SYM_IDLE;
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst)
            r_data_out <= 16'd0;
        else if (r_state == ST_CL0 && bus.enable_deser)
            r_data_out <= {(w_lane1_act ? bus.lane_1_rx_i : 8'h00), bus.lane_0_rx_i};
        else
            r_data_out <= 16'd0;
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (bus.c_address)
            ADDR_ID:     w_rd_mux = LL_ID;
            ADDR_STATUS: w_rd_mux = {29'd0, r_state};
            ADDR_CTRL:   w_rd_mux = {30'd0, r_ctrl};
`ifdef LL_OS_ERR_CNT_EN
            ADDR_ERR:    w_rd_mux = {16'd0, r_err_cnt};
`else
            ADDR_ERR:    w_rd_mux = 32'd0;
`endif
            default:     w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            r_ctrl       <= 2'b01;
            r_c_data_out <= 32'd0;
        end else begin
            if (bus.c_write && bus.c_address == ADDR_CTRL) r_ctrl <= bus.c_data_in[1:0];
            if (bus.c_read) r_c_data_out <= w_rd_mux;
        end
    end

`ifdef LL_OS_ERR_CNT_EN
    assign w_err_sum = {1'b0, r_err_cnt} + {16'd0, w_err0} + {16'd0, w_err1};

    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst)
            r_err_cnt <= 16'd0;
        else if (bus.c_write && bus.c_address == ADDR_ERR)
            r_err_cnt <= 16'd0;
        else if (r_state == ST_TS1 || r_state == ST_TS2)
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
`endif

    assign bus.lane_0_tx_o              = w_tx0;
    assign bus.lane_1_tx_o              = w_tx1;
    assign bus.sbtx                     = (r_state != ST_DISABLED);
    assign bus.enable_scr               = (r_state == ST_CL0);
    assign bus.transport_layer_data_out = r_data_out;
    assign bus.c_data_out               = r_c_data_out;

endmodule

// File: tb/tb_usb4_logical_layer_no_scr.sv
// Self-checking bench for usb4_logical_layer_no_scr: config reads, sideband
// connect, dual/single-lane training, CL0 striping and link teardown.
module tb_usb4_logical_layer_no_scr;

    logic local_clk = 1'b0;
    logic rst       = 1'b0;
    always #5 local_clk = ~local_clk;

    usb4_logical_layer_no_scr_if bus();

    usb4_logical_layer_no_scr dut (
        .local_clk (local_clk),
        .rst       (rst),
        .bus       (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
        string       name;
    } rd_vec_t;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        logic        en;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        logic [15:0] dout;
    } dv_t;

    sb_t     q_exp[$];
    rd_vec_t rv[6];
    dv_t     dv[4];
    int      n_vec = 0;
    int      n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (q_exp.size() == 0) begin
            timeout_fail("scoreboard_empty");
        end else begin
            e = q_exp.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic cfg_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        bus.c_read    = 1'b1;
        bus.c_address = a;
        q_exp.push_back('{name, exp});
        tick();
        bus.c_read = 1'b0;
        sb_pop(bus.c_data_out);
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        bus.c_write   = 1'b1;
        bus.c_address = a;
        bus.c_data_in = d;
        tick();
        bus.c_write = 1'b0;
    endtask

    task automatic cl0_vec(input dv_t v, input string name);
        bus.transport_layer_data_in = v.din;
        bus.lane_0_rx_i  = v.rx0;
        bus.lane_1_rx_i  = v.rx1;
        bus.enable_deser = v.en;
        #1;
        chk({name, "_tx0"}, {24'd0, bus.lane_0_tx_o}, {24'd0, v.tx0});
        chk({name, "_tx1"}, {24'd0, bus.lane_1_tx_o}, {24'd0, v.tx1});
        q_exp.push_back('{{name, "_dout"}, {16'd0, v.dout}});
        tick();
        sb_pop({16'd0, bus.transport_layer_data_out});
    endtask

    // Feeds 8 TS1 then TS2 ordered sets until the DUT enters CL0.
    task automatic train(input bit dual, output int ts2_seen, output bit ok);
        logic [7:0] prev;
        logic [7:0] t;
        int         k;
        int         b;
        prev     = 8'h00;
        ts2_seen = 0;
        ok       = 1'b0;
        bus.enable_deser = 1'b1;
        for (int c = 0; c < 400; c++) begin
            k = c / 4;
            b = c % 4;
            t = (k < 8) ? 8'h01 : 8'h02;
            case (b)
                0: begin bus.lane_0_rx_i = 8'hBC; bus.lane_1_rx_i = 8'hBC; end
                1: begin bus.lane_0_rx_i = t;     bus.lane_1_rx_i = t;     end
                2: begin bus.lane_0_rx_i = 8'h00; bus.lane_1_rx_i = 8'h01; end
                default: begin bus.lane_0_rx_i = 8'h00; bus.lane_1_rx_i = 8'h00; end
            endcase
            if (!dual) bus.lane_1_rx_i = 8'h00;
            tick();
            if (prev == 8'hBC && bus.lane_0_tx_o == 8'h02) ts2_seen++;
            prev = bus.lane_0_tx_o;
            if (bus.enable_scr) begin
                ok = 1'b1;
                break;
            end
        end
        bus.lane_0_rx_i  = 8'h00;
        bus.lane_1_rx_i  = 8'h00;
        bus.enable_deser = 1'b0;
    endtask

    initial begin
        logic [31:0] os0, os1;
        int          ts2_seen;
        bit          ok;
        bit          found;

        rv[0] = '{8'h00, 32'h5553_4234, "rd_id"};
        rv[1] = '{8'h01, 32'h0000_0000, "rd_status_reset"};
        rv[2] = '{8'h02, 32'h0000_0001, "rd_ctrl_reset"};
        rv[3] = '{8'h03, 32'h0000_0000, "rd_err_default"};
        rv[4] = '{8'h55, 32'h0000_0000, "rd_unmapped"};
        rv[5] = '{8'hFF, 32'h0000_0000, "rd_unmapped_top"};

        dv[0] = '{16'hA55A, 8'h12, 8'h34, 1'b1, 8'h5A, 8'hA5, 16'h3412};
        dv[1] = '{16'h0000, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 16'h00FF};
        dv[2] = '{16'hFFFF, 8'hAB, 8'hCD, 1'b0, 8'hFF, 8'hFF, 16'h0000};
        dv[3] = '{16'h1234, 8'h01, 8'h80, 1'b1, 8'h34, 8'h12, 16'h8001};

        bus.lane_disable = 1'b1;
        bus.c_read = 1'b0;
        bus.c_write = 1'b0;
        bus.c_address = 8'h00;
        bus.c_data_in = 32'h0;
        bus.transport_layer_data_in = 16'h0;
        bus.lane_0_rx_i = 8'h00;
        bus.lane_1_rx_i = 8'h00;
        bus.enable_deser = 1'b0;
        bus.sbrx = 1'b0;
        repeat (3) @(posedge local_clk);
        #2 rst = 1'b1;
        tick();

        chk("rst_sbtx",       {31'd0, bus.sbtx},       32'd0);
        chk("rst_enable_scr", {31'd0, bus.enable_scr}, 32'd0);
        chk("rst_tx0",        {24'd0, bus.lane_0_tx_o}, 32'd0);
        chk("rst_dout",       {16'd0, bus.transport_layer_data_out}, 32'd0);
        chk("rst_cdo",        bus.c_data_out, 32'd0);

        for (int i = 0; i < 6; i++) cfg_read(rv[i].addr, rv[i].exp, rv[i].name);

        cfg_write(8'h00, 32'hDEAD_BEEF);
        cfg_read(8'h00, 32'h5553_4234, "ro_write_ignored");
        chk("sbtx_disabled", {31'd0, bus.sbtx}, 32'd0);

        bus.lane_disable = 1'b0;
        tick();
        cfg_read(8'h01, 32'd1, "status_wait_sb");
        chk("sbtx_wait_sb", {31'd0, bus.sbtx}, 32'd1);

        bus.sbrx = 1'b1;
        repeat (15) tick();
        chk("ts1_not_early", {24'd0, bus.lane_0_tx_o}, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.lane_0_tx_o == 8'hBC) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) timeout_fail("wait_ts1");
        os0 = '0;
        os1 = '0;
        for (int i = 0; i < 4; i++) begin
            os0 = {os0[23:0], bus.lane_0_tx_o};
            os1 = {os1[23:0], bus.lane_1_tx_o};
            if (i < 3) tick();
        end
        chk("ts1_lane0", os0, 32'hBC01_0000);
        chk("ts1_lane1", os1, 32'hBC01_0100);
        tick();

        train(1'b1, ts2_seen, ok);
        if (!ok) timeout_fail("train_dual");
        chk("ts2_min_sent", {31'd0, ts2_seen >= 16}, 32'd1);
        cfg_read(8'h01, 32'd4, "status_cl0");

        for (int i = 0; i < 4; i++) cl0_vec(dv[i], $sformatf("cl0_v%0d", i));

        cfg_write(8'h02, 32'h0);
        cfg_write(8'h02, 32'h3);
        cfg_read(8'h02, 32'h3, "ctrl_single");
        train(1'b0, ts2_seen, ok);
        if (!ok) timeout_fail("train_single");
        cl0_vec('{16'hA55A, 8'h12, 8'h34, 1'b1, 8'h5A, 8'h00, 16'h0012}, "single");

        bus.c_read    = 1'b1;
        bus.c_write   = 1'b1;
        bus.c_address = 8'h02;
        bus.c_data_in = 32'h1;
        q_exp.push_back('{"rw_same_addr_old", 32'h3});
        tick();
        bus.c_read  = 1'b0;
        bus.c_write = 1'b0;
        sb_pop(bus.c_data_out);
        cfg_read(8'h02, 32'h1, "ctrl_after_rw");

        bus.sbrx = 1'b0;
        repeat (10) tick();
        chk("scr_hold_before_debounce", {31'd0, bus.enable_scr}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!bus.enable_scr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) timeout_fail("wait_sb_drop");
        cfg_read(8'h01, 32'd1, "status_after_drop");
        chk("sbtx_after_drop", {31'd0, bus.sbtx}, 32'd1);
        chk("tx0_after_drop", {24'd0, bus.lane_0_tx_o}, 32'd0);

        bus.lane_disable = 1'b1;
        tick();
        chk("sbtx_disable", {31'd0, bus.sbtx}, 32'd0);
        cfg_read(8'h01, 32'd0, "status_disable");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
